// File: rtl/aes_pkg.sv
// Shared AES SubBytes types plus the GF(2^8) helpers behind the forward and inverse S-boxes.
package aes_pkg;

    localparam int NUM_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
    function automatic byte_t gf_inv(input byte_t a);
        byte_t x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a);
        return gf_mul(x127, x127);
    endfunction

    function automatic byte_t rotl8(input byte_t x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic byte_t sbox_fwd(input byte_t a);
        byte_t x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic byte_t sbox_inv(input byte_t a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane: forward and inverse S-box, selected by the latched block mode.
// Purely combinational, zero latency, no flow control of its own.
module sbox_lane
    import aes_pkg::*;
(
    input  logic  i_inv,
    input  byte_t i_byte,
    output byte_t o_byte
);

    byte_t w_fwd;
    byte_t w_inv;

    assign w_fwd  = sbox_fwd(i_byte);
    assign w_inv  = sbox_inv(i_byte);
    assign o_byte = i_inv ? w_inv : w_fwd;

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes over a 128-bit state using LANES time-multiplexed S-box lanes.
// Latency 16/LANES cycles accept-to-out_valid (+1 with SUB_BYTES_PIPE_EN defined, lane outputs registered).
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int N  = NUM_BYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [8*NUM_BYTES-1:0] r_data;
    logic                   r_mode;
    logic [8*LANES-1:0]     w_lane_in;
    logic [8*LANES-1:0]     w_lane_out;
    logic                   w_chunk_last;
    logic                   w_busy_end;

    assign w_chunk_last = (r_cnt == CW'(N - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_in[l*8 +: 8] = r_data[(int'(r_cnt) * LANES + l) * 8 +: 8];
        sbox_lane u_lane (
            .i_inv  (r_mode),
            .i_byte (w_lane_in[l*8 +: 8]),
            .o_byte (w_lane_out[l*8 +: 8])
        );
    end

`ifdef SUB_BYTES_PIPE_EN
    logic               r_pipe_vld;
    logic [CW-1:0]      r_pipe_idx;
    logic [8*LANES-1:0] r_pipe_dat;
    logic               r_flush;

    // r_flush marks the extra BUSY cycle that retires the last registered chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= 1'b0;
            r_pipe_idx <= '0;
            r_pipe_dat <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_pipe_vld <= (r_state == BUSY) && !r_flush;
            r_pipe_idx <= r_cnt;
            r_pipe_dat <= w_lane_out;
            r_flush    <= (r_state == BUSY) && !r_flush && w_chunk_last;
        end
    end

    assign w_busy_end = r_flush;
`else
    assign w_busy_end = w_chunk_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (w_busy_end) w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter parks on the last chunk so the lane read index never leaves the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_mode <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_data <= in_data;
            r_mode <= mode;
            r_cnt  <= '0;
        end else if (r_state == BUSY) begin
            if (!w_chunk_last) r_cnt <= r_cnt + CW'(1);
`ifdef SUB_BYTES_PIPE_EN
            if (r_pipe_vld) begin
                for (int l = 0; l < LANES; l++) begin
                    r_data[(int'(r_pipe_idx) * LANES + l) * 8 +: 8] <= r_pipe_dat[l*8 +: 8];
                end
            end
`else
            for (int l = 0; l < LANES; l++) begin
                r_data[(int'(r_cnt) * LANES + l) * 8 +: 8] <= w_lane_out[l*8 +: 8];
            end
`endif
        end
    end

    assign out_data = r_data;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: five instances (LANES 1..16) checked against a table-driven S-box model.
module tb_sub_bytes_engine;

    localparam int ND = 5;
`ifdef SUB_BYTES_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         mode      [ND];
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [127:0] in_data   [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] out_data  [ND];
    logic         busy      [ND];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .mode      (mode[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fwd_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_tab [256];

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = m ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one block, then scrambles mode/in_data once it has been taken.
    task automatic accept_block(input int d, input logic m, input logic [127:0] data);
        @(negedge clk);
        check("in_ready_before_accept", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        mode[d]     = m;
        in_data[d]  = data;
        @(negedge clk);
        in_valid[d] = 1'b0;
        mode[d]     = ~m;
        in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic run_block(input int d, input logic m, input logic [127:0] data,
                             output logic [127:0] res, output int lat);
        accept_block(d, m, data);
        wait_done(d, lat);
        res = out_data[d];
        drain(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] res2;
        logic [127:0] data;
        logic         m;
        int           lat;

        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
        for (int d = 0; d < ND; d++) begin
            mode[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int d = 0; d < ND; d++) begin
            check("rst_in_ready", 128'(in_ready[d]), 128'd1);
            check("rst_out_valid", 128'(out_valid[d]), 128'd0);
            check("rst_busy", 128'(busy[d]), 128'd0);
            check("rst_out_data", out_data[d], 128'd0);
        end

        // LANES=4 instance: basic forward and inverse vectors.
        run_block(2, 1'b0, 128'd0, res, lat);
        check("fwd_zero", res, {16{8'h63}});
        check("fwd_zero_latency", 128'(lat), 128'(4 + PIPE));
        run_block(2, 1'b1, {16{8'h63}}, res, lat);
        check("inv_63", res, 128'd0);
        run_block(2, 1'b1, {{15{8'h63}}, 8'h00}, res, lat);
        check("inv_byte0", res, {{15{8'h00}}, 8'h52});

        // Round trip of every byte value on every lane count.
        for (int d = 0; d < ND; d++) begin
            for (int b = 0; b < 16; b++) begin
                for (int k = 0; k < 16; k++) data[8*k +: 8] = 8'(16 * b + k);
                run_block(d, 1'b0, data, res, lat);
                check("rt_fwd", res, ref_sub(data, 1'b0));
                if (b == 0) begin
                    check("rt_latency", 128'(lat), 128'((16 >> d) + PIPE));
                    check("spot_S01", 128'(res[15:8]), 128'h7c);
                end
                if (b == 5) check("spot_S53", 128'(res[31:24]), 128'hed);
                run_block(d, 1'b1, res, res2, lat);
                check("rt_identity", res2, data);
            end
            for (int r = 0; r < 6; r++) begin
                data = {$urandom, $urandom, $urandom, $urandom};
                m    = 1'($urandom_range(0, 1));
                run_block(d, m, data, res, lat);
                check("rand_block", res, ref_sub(data, m));
            end
        end

        // Backpressure in DONE with an in_valid pulse that must be ignored.
        data = {$urandom, $urandom, $urandom, $urandom};
        accept_block(2, 1'b0, data);
        wait_done(2, lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid[2]), 128'd1);
            check("bp_out_data", out_data[2], ref_sub(data, 1'b0));
            check("bp_in_ready", 128'(in_ready[2]), 128'd0);
            check("bp_busy", 128'(busy[2]), 128'd1);
            in_valid[2] = (i == 4);
            in_data[2]  = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
            @(negedge clk);
        end
        in_valid[2] = 1'b0;
        drain(2);
        check("bp_pulse_ignored_valid", 128'(out_valid[2]), 128'd0);
        check("bp_pulse_ignored_busy", 128'(busy[2]), 128'd0);
        check("bp_idle_ready", 128'(in_ready[2]), 128'd1);

        // Reset while the block is halfway through its chunks.
        accept_block(2, 1'b0, {16{8'hA5}});
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 128'(busy[2]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid[2]), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready[2]), 128'd1);
        check("mid_rst_busy", 128'(busy[2]), 128'd0);
        check("mid_rst_out_data", out_data[2], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data = {$urandom, $urandom, $urandom, $urandom};
        run_block(2, 1'b1, data, res, lat);
        check("post_rst_block", res, ref_sub(data, 1'b1));
        check("post_rst_latency", 128'(lat), 128'(4 + PIPE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
